// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze generation for the 5-stage core, with a data-memory
// watchdog and saturating debug counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_Rt,
    input  logic [4:0]       if_id_Rs,
    input  logic [4:0]       if_id_Rt,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_MemRead,
    input  logic             ex_mem_MemWrite,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WC_W = 16;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            lu, mem_busy, watchdog, freeze;

    assign lu       = id_ex_MemRead && (id_ex_Rt != REG_ZERO) &&
                      ((id_ex_Rt == if_id_Rs) || (id_ex_Rt == if_id_Rt));
    assign mem_busy = (ex_mem_MemRead || ex_mem_MemWrite) && !dmem_ready;
    assign watchdog = (state == MEM_WAIT) && !dmem_ready &&
                      (wait_cnt == WC_W'(TIMEOUT - 1));
    // The watchdog cycle releases the pipe even though the access is still pending.
    assign freeze   = (mem_busy || (state == MEM_WAIT && !dmem_ready)) && !watchdog;

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst) begin
            if (freeze) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: if (mem_busy) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= '0;
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                    end else if (watchdog) begin
                        state   <= RUN;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .en   (!pc_write),
        .count(stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .clr  (rst),
        .en   (if_id_flush),
        .count(flush_count)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: full-width instance plus a 2-bit-counter
// instance on the same stimulus for the saturation case.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_ex_MemRead;
    logic [4:0] id_ex_Rt, if_id_Rs, if_id_Rt;
    logic       ex_branch_taken, ex_mem_MemRead, ex_mem_MemWrite, dmem_ready;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_err;
    logic [15:0] stall_count, flush_count;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_freeze, s_mem_err;
    logic [1:0]  s_stall_count, s_flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_Rt(id_ex_Rt),
        .if_id_Rs(if_id_Rs), .if_id_Rt(if_id_Rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pipe_freeze(pipe_freeze), .mem_err(mem_err),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) u_sat (
        .clk(clk), .rst(rst),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_Rt(id_ex_Rt),
        .if_id_Rs(if_id_Rs), .if_id_Rt(if_id_Rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .dmem_ready(dmem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .pipe_freeze(s_pipe_freeze), .mem_err(s_mem_err),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}, {27'd0, exp});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        id_ex_MemRead = 1'b0; id_ex_Rt = 5'd0; if_id_Rs = 5'd0; if_id_Rt = 5'd0;
        ex_branch_taken = 1'b0; ex_mem_MemWrite = 1'b0;
        ex_mem_MemRead = 1'b1; dmem_ready = 1'b0;

        // Outputs forced while in reset even with a busy memory request
        mid(); chk_ctl("rst_force", 5'b11000);
        nxt(); ex_mem_MemRead = 1'b0;
        mid();
        chk("rst_stall", stall_count, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_mem_err", mem_err, 0);
        nxt(); rst = 1'b0;
        mid(); chk_ctl("idle", 5'b11000);

        // Load-use on Rs
        nxt(); id_ex_MemRead = 1'b1; id_ex_Rt = 5'd9; if_id_Rs = 5'd9; if_id_Rt = 5'd3;
        mid(); chk_ctl("lu_rs", 5'b00010);
        nxt(); id_ex_MemRead = 1'b0;
        mid(); chk_ctl("lu_after", 5'b11000); chk("stall_lu1", stall_count, 1);

        // Load to $zero never stalls
        nxt(); id_ex_MemRead = 1'b1; id_ex_Rt = 5'd0; if_id_Rs = 5'd0; if_id_Rt = 5'd0;
        mid(); chk_ctl("lu_zero", 5'b11000);
        // Load-use on Rt
        nxt(); id_ex_Rt = 5'd9; if_id_Rs = 5'd3; if_id_Rt = 5'd9;
        mid(); chk_ctl("lu_rt", 5'b00010);
        nxt(); id_ex_MemRead = 1'b0;
        mid(); chk("stall_lu2", stall_count, 2);

        // Branch wins over load-use
        nxt(); id_ex_MemRead = 1'b1; ex_branch_taken = 1'b1;
        mid(); chk_ctl("br_lu", 5'b11110);
        nxt(); id_ex_MemRead = 1'b0; ex_branch_taken = 1'b0;
        mid(); chk("flush_br", flush_count, 1); chk("stall_br", stall_count, 2);

        // 3-cycle memory wait, release when ready rises
        nxt(); ex_mem_MemRead = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid(); chk_ctl("mem_wait", 5'b00001);
            nxt();
        end
        dmem_ready = 1'b1;
        mid(); chk_ctl("mem_release", 5'b11000);
        nxt(); ex_mem_MemRead = 1'b0;
        mid(); chk("stall_mem", stall_count, 5);

        // Single-cycle access: ready already high
        nxt(); ex_mem_MemRead = 1'b1; dmem_ready = 1'b1;
        mid(); chk_ctl("mem_1cyc", 5'b11000);
        nxt(); ex_mem_MemRead = 1'b0;
        mid(); chk("stall_1cyc", stall_count, 5);

        // Branch deferred behind a 2-cycle store wait
        nxt(); ex_branch_taken = 1'b1; ex_mem_MemWrite = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mid(); chk_ctl("br_deferred", 5'b00001);
            nxt();
        end
        dmem_ready = 1'b1;
        mid(); chk_ctl("br_release", 5'b11110);
        nxt(); ex_branch_taken = 1'b0; ex_mem_MemWrite = 1'b0;
        mid(); chk("flush_def", flush_count, 2); chk("stall_def", stall_count, 7);

        // Watchdog: RUN cycle plus three MEM_WAIT cycles frozen, fires on wait_cnt==3
        nxt(); ex_mem_MemRead = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid(); chk_ctl("wd_freeze", 5'b00001);
            nxt();
        end
        mid(); chk_ctl("wd_fire", 5'b11000); chk("wd_err_pre", mem_err, 0);
        nxt(); ex_mem_MemRead = 1'b0;
        // Still ready low: MEM_WAIT would freeze, so no freeze proves RUN
        mid(); chk_ctl("wd_run", 5'b11000); chk("wd_err", mem_err, 1);
        chk("stall_wd", stall_count, 11);
        nxt();
        mid(); chk("wd_err_sticky", mem_err, 1);
        chk("sat_stall", s_stall_count, 3);
        chk("sat_flush", s_flush_count, 2);

        // Reset in the middle of a memory wait
        nxt(); ex_mem_MemRead = 1'b1;
        mid(); chk_ctl("pre_rst_freeze", 5'b00001);
        nxt(); rst = 1'b1;
        mid(); chk_ctl("rst_mid", 5'b11000);
        nxt(); rst = 1'b0; ex_mem_MemRead = 1'b0;
        mid();
        chk_ctl("rst_run", 5'b11000);
        chk("rst2_mem_err", mem_err, 0);
        chk("rst2_stall", stall_count, 0);
        chk("rst2_flush", flush_count, 0);
        chk("rst2_sat_stall", s_stall_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline hazard controller for the 5-stage MIPS core. It produces every stall, freeze and flush control for the pipeline registers. Sources are the load-use hazard (ID vs EX), taken branches resolved in EX, and multi-cycle data-memory accesses in MEM, which use a ready handshake. It also keeps a data-memory watchdog and saturating stall and flush counters that the debug path reads.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters
- TIMEOUT, 255, maximum MEM_WAIT cycles before the watchdog fires (1..2^16-1)

Ports:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_ex_MemRead  in  1  instruction in EX is a load
- id_ex_Rt  in  5  destination of the load in EX
- if_id_Rs, if_id_Rt  in  5 each  source registers of the instruction in ID
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- ex_mem_MemRead, ex_mem_MemWrite  in  1 each  MEM-stage access active
- dmem_ready  in  1  data memory has completed the current access
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID cleared to a NOP
- id_ex_flush  out  1  ID/EX control bits cleared (bubble)
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_err  out  1  sticky watchdog flag
- stall_count  out  CNT_W  cycles in which pc_write was low
- flush_count  out  CNT_W  taken-branch flushes applied

## Operation
- Decode terms:
  - lu = id_ex_MemRead & id_ex_Rt!=0 & (id_ex_Rt==if_id_Rs | id_ex_Rt==if_id_Rt)
  - mem_busy = (ex_mem_MemRead | ex_mem_MemWrite) & ~dmem_ready
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_busy.
  - MEM_WAIT -> RUN when dmem_ready, or when the watchdog fires.
- Watchdog:
  - wait_cnt clears on entry to MEM_WAIT and increments each cycle spent there.
  - When wait_cnt==TIMEOUT-1 and dmem_ready is still low, set mem_err and force the return to RUN. The access is treated as complete.
  - mem_err clears only on rst.
- Output priority, evaluated each cycle; the first matching rule wins:
  1. mem_busy, or state==MEM_WAIT & ~dmem_ready & ~watchdog: pipe_freeze=1, pc_write=0, if_id_write=0, no flushes. A branch or load-use present at the same time is deferred. Both are held frozen in their stages and handled after release.
  2. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1. Any load-use is ignored because the ID instruction is squashed.
  3. lu: pc_write=0, if_id_write=0, id_ex_flush=1, for exactly one bubble.
  4. Otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- Control outputs are combinational (Mealy) from the inputs and the registered state. The state, wait_cnt, mem_err and the counters are registered.
- stall_count increments on every cycle where pc_write=0. flush_count increments on every cycle where rule 2 fires. Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset values: state=RUN, wait_cnt=0, mem_err=0, stall_count=0, flush_count=0.
- While rst=1, outputs are forced to pc_write=1, if_id_write=1, all flushes and the freeze 0. Reset mid-MEM_WAIT returns to RUN on the next edge.
- Load-use response has zero latency: the controls take effect in the cycle the hazard is visible. Exactly one stall cycle occurs per hazard, because the bubble clears id_ex_MemRead.
- Branch flush has zero latency: one cycle, two instructions squashed.
- Memory wait lasts as long as dmem_ready is low. Release happens in the same cycle dmem_ready rises, so a 1-cycle access (ready already high) gives no stall.
- Watchdog firing is the TIMEOUT-th wait cycle. In that cycle the outputs follow rules 2–4, not rule 1.
- A counter update is visible one cycle after the qualifying cycle.

## Structure
- A shared package (hazard_pkg) holds the state typedef (RUN, MEM_WAIT) and the REG_ZERO=5'd0 constant.
- One sub-module, sat_counter (parameterised width, increment enable, synchronous clear), is instantiated twice.
- The FSM, watchdog and priority decode are top level.

## Test plan
- Load-use: lw writes $t1 = reg 9 in EX and ID reads Rs=9 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1 on the next cycle. The same case with id_ex_Rt=0 gives no stall.
- Branch: ex_branch_taken=1 together with lu=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1 and stall_count unchanged.
- Memory wait: MemRead with dmem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, release in the cycle ready rises, stall_count=3.
- Deferred branch: ex_branch_taken held during a 2-cycle memory wait -> no flush while frozen, flush on the release cycle.
- Watchdog: TIMEOUT=4 with dmem_ready stuck low -> freeze for 3 cycles, mem_err=1 and state RUN from the 4th cycle; mem_err stays set until rst.
- Saturation and reset: CNT_W=2 with 5 stall cycles -> stall_count=3; rst asserted mid-MEM_WAIT -> all registers return to their reset values after one edge.
